// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C I/O expander: FSM states and bus-level
// protocol values.
package i2c_pkg;

    localparam int   ADDR_WIDTH = 7;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_slave_io_expander_if.sv
// Expander bus bundle: raw SCL, static device address, port pins and status.
// The FSM state is carried alongside so checkers can bind to it.
interface i2c_slave_io_expander_if #(
    parameter int NUM_PORTS = 1
);
    import i2c_pkg::*;

    logic                    scl;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [8*NUM_PORTS-1:0]  io;
    logic [8*NUM_PORTS-1:0]  io_in;
    logic                    int_n;
    logic                    busy;
    i2c_state_e              dbg_state;

    modport slave  (input  scl, adr, io_in, output io, int_n, busy, dbg_state);
    modport master (output scl, adr, io_in, input  io, int_n, busy, dbg_state);

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus a FILTER_DEPTH-sample glitch filter for one I2C line,
// with single-clock rise/fall strobes aligned to the filtered level change.
module i2c_line_filter #(
    parameter int FILTER_DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_differs;
    logic          w_settled;

    // The level flips on the FILTER_DEPTH-th consecutive differing sample.
    assign w_differs = (r_sync[1] != r_level);
    assign w_settled = w_differs && (r_cnt == CW'(FILTER_DEPTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_rise <= w_settled & r_sync[1];
            r_fall <= w_settled & ~r_sync[1];
            if (w_settled) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_io_expander.sv
// PCF8574/PCF8575-style I2C slave: NUM_PORTS writable output bytes, readback of
// the synchronised input pins, and an input-change interrupt.
module i2c_slave_io_expander #(
    parameter int         NUM_PORTS    = 1,
    parameter int         FILTER_DEPTH = 3,
    parameter logic [7:0] RESET_VALUE  = 8'hFF
) (
    input  logic clk,
    input  logic reset,
    inout  wire  sda,
    i2c_slave_io_expander_if.slave bus
);
    import i2c_pkg::*;

    localparam int W  = 8 * NUM_PORTS;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    i2c_state_e    r_state, w_state_nxt;
    logic [3:0]    r_bit_ct, w_bit_ct_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_tx, w_tx_nxt;
    logic [PW-1:0] r_port_idx, w_port_nxt, w_port_inc;
    logic          r_sda_oe, w_sda_oe_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_int_n;
    logic [W-1:0]  r_io, w_io_nxt;
    logic [W-1:0]  r_in_s1, r_in_s2, r_snap, w_snap_nxt;
    logic [1:0]    r_init;
    logic [7:0]    w_rd_byte;
    logic          w_load, w_int_clr, w_in_diff;
    logic          w_scl_lvl, w_scl_rise, w_scl_fall;
    logic          w_sda_lvl, w_sda_rise, w_sda_fall;
    logic          w_start, w_stop;

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_filter (
        .clk(clk), .reset(reset), .i_line(bus.scl),
        .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_filter (
        .clk(clk), .reset(reset), .i_line(sda),
        .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    assign w_start    = w_sda_fall & w_scl_lvl;
    assign w_stop     = w_sda_rise & w_scl_lvl;
    assign w_rd_byte  = r_in_s2[8*r_port_idx +: 8];
    assign w_port_inc = (r_port_idx == PW'(NUM_PORTS - 1)) ? '0 : r_port_idx + PW'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_bit_ct_nxt = r_bit_ct;
        w_shift_nxt  = r_shift;
        w_tx_nxt     = r_tx;
        w_port_nxt   = r_port_idx;
        w_sda_oe_nxt = r_sda_oe;
        w_busy_nxt   = r_busy;
        w_io_nxt     = r_io;
        w_load       = 1'b0;
        w_int_clr    = 1'b0;
        if (w_start) begin
            w_state_nxt  = ADDR;
            w_bit_ct_nxt = '0;
            w_port_nxt   = '0;
            w_busy_nxt   = 1'b1;
            w_sda_oe_nxt = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = IDLE;
            w_bit_ct_nxt = '0;
            w_busy_nxt   = 1'b0;
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                ADDR, WRITE: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = {r_shift[6:0], w_sda_lvl};
                        w_bit_ct_nxt = r_bit_ct + 4'd1;
                    end else if (w_scl_fall && (r_bit_ct == 4'd8)) begin
                        w_bit_ct_nxt = '0;
                        if (r_state == WRITE) begin
                            w_sda_oe_nxt = 1'b1;
                            w_state_nxt  = WRITE_ACK;
                        end else if (r_shift[7:1] == bus.adr) begin
                            w_sda_oe_nxt = 1'b1;
                            w_state_nxt  = ADDR_ACK;
                        end else begin
                            w_state_nxt  = IGNORE;
                        end
                    end
                end
                // Interrupt clears as the address ACK completes, together with the
                // read snapshot load, so a read of the changed pins leaves int_n high.
                ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_int_clr = 1'b1;
                        if (r_shift[0]) begin
                            w_load       = 1'b1;
                            w_tx_nxt     = w_rd_byte;
                            w_sda_oe_nxt = ~w_rd_byte[7];
                            w_state_nxt  = READ;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = WRITE;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (w_scl_rise) begin
                        w_io_nxt[8*r_port_idx +: 8] = r_shift;
                    end else if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_port_nxt   = w_port_inc;
                        w_state_nxt  = WRITE;
                    end
                end
                READ: begin
                    if (w_scl_rise) begin
                        w_bit_ct_nxt = r_bit_ct + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_ct == 4'd8) begin
                            w_sda_oe_nxt = 1'b0;
                            w_bit_ct_nxt = '0;
                            w_state_nxt  = READ_ACK;
                        end else begin
                            w_tx_nxt     = {r_tx[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_tx[6];
                        end
                    end
                end
                READ_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda_lvl == I2C_NACK) w_state_nxt = IGNORE;
                        else                       w_port_nxt  = w_port_inc;
                    end else if (w_scl_fall) begin
                        w_load       = 1'b1;
                        w_tx_nxt     = w_rd_byte;
                        w_sda_oe_nxt = ~w_rd_byte[7];
                        w_bit_ct_nxt = '0;
                        w_state_nxt  = READ;
                    end
                end
                default: ;
            endcase
        end
    end

    // Snapshot tracks the pins until the synchroniser is primed; the compare is
    // against the post-load snapshot so a load never flags itself.
    assign w_snap_nxt = ((r_init != 2'd3) || w_load) ? r_in_s2 : r_snap;
    assign w_in_diff  = (r_init == 2'd3) && (r_in_s2 != w_snap_nxt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_bit_ct   <= '0;
            r_shift    <= '0;
            r_tx       <= '0;
            r_port_idx <= '0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_int_n    <= 1'b1;
            r_io       <= {NUM_PORTS{RESET_VALUE}};
            r_in_s1    <= '0;
            r_in_s2    <= '0;
            r_snap     <= '0;
            r_init     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_ct   <= w_bit_ct_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_port_idx <= w_port_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_io       <= w_io_nxt;
            r_in_s1    <= bus.io_in;
            r_in_s2    <= r_in_s1;
            r_snap     <= w_snap_nxt;
            if (r_init != 2'd3) r_init <= r_init + 2'd1;
            if (w_in_diff)      r_int_n <= 1'b0;
            else if (w_int_clr) r_int_n <= 1'b1;
        end
    end

    assign sda           = r_sda_oe ? I2C_ACK : 1'bz;
    assign bus.io        = r_io;
    assign bus.int_n     = r_int_n;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_i2c_slave_io_expander.sv
// Directed bench for the I2C I/O expander: a bit-banged master with an open-drain
// SDA and pull-up, writes, reads, aborts, glitches and the input-change interrupt.
module tb_i2c_slave_io_expander;

    localparam int NUM_PORTS = 2;
    localparam int W         = 8 * NUM_PORTS;
    localparam int Q         = 8;

    logic clk = 1'b0;
    logic reset;
    logic m_sda_low;
    wire  sda;

    int n_cmp = 0;
    int n_err = 0;

    logic mon_busy = 1'b0;
    logic mon_sda  = 1'b0;
    int   busy_drop_ct = 0;
    int   sda_low_ct   = 0;

    logic [W-1:0] exp_q[$];

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave_io_expander_if #(.NUM_PORTS(NUM_PORTS)) bus ();

    i2c_slave_io_expander #(
        .NUM_PORTS(NUM_PORTS), .FILTER_DEPTH(3), .RESET_VALUE(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .sda(sda), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_busy && bus.busy !== 1'b1) busy_drop_ct++;
        if (mon_sda && !m_sda_low && sda !== 1'b1) sda_low_ct++;
    end

    logic glitch_en = 1'b0;

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wq();
        bus.scl = 1'b1;   wq();
        m_sda_low = 1'b1; wq();
        bus.scl = 1'b0;   wq();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wq();
        bus.scl = 1'b1;   wq();
        m_sda_low = 1'b0; wq();
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b; wq();
        bus.scl = 1'b1; wq();
        if (glitch_en) begin
            // 1-clk SDA pulse while SCL is high would read as START/STOP unfiltered
            m_sda_low = b;  @(negedge clk);
            m_sda_low = ~b; repeat (3) @(negedge clk);
            bus.scl = 1'b0; @(negedge clk);
            bus.scl = 1'b1; repeat (3) @(negedge clk);
        end else begin
            wq();
        end
        bus.scl = 1'b0; wq();
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack,
                             output logic [W-1:0] io_pre, output logic [W-1:0] io_post);
        send_bits(d, 8);
        m_sda_low = 1'b0; wq();
        io_pre  = bus.io;
        bus.scl = 1'b1;   wq();
        ack     = sda;
        io_post = bus.io;
        wq();
        bus.scl = 1'b0;   wq();
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = 1'b0; wq();
            bus.scl = 1'b1;   wq();
            d[i] = sda;
            wq();
            bus.scl = 1'b0;   wq();
        end
        m_sda_low = (mack == 1'b0); wq();
        bus.scl = 1'b1; wq(); wq();
        bus.scl = 1'b0; wq();
        m_sda_low = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.scl = 1'b1; m_sda_low = 1'b0;
        bus.adr = 7'h20; bus.io_in = 16'h5A81;
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.io !== 16'hFFFF) begin n_err++; $display("FAIL reset_io: got %h want ffff", bus.io); end
        n_cmp++; if (bus.int_n !== 1'b1) begin n_err++; $display("FAIL reset_int_n: got %b want 1", bus.int_n); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b want 1 (released)", sda); end
        reset = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++; if (bus.io !== 16'hFFFF) begin n_err++; $display("FAIL post_reset_io: got %h want ffff", bus.io); end
        n_cmp++; if (bus.int_n !== 1'b1) begin n_err++; $display("FAIL post_reset_int_n: got %b want 1", bus.int_n); end
    endtask

    task automatic test_write();
        logic         ack;
        logic [W-1:0] pre, post, expv, prev;
        logic [7:0]   d [3];
        d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'h77;
        exp_q = {16'hFFA5, 16'h3CA5, 16'h3C77};
        prev = 16'hFFFF;
        i2c_start();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", bus.busy); end
        send_byte(8'h40, ack, pre, post);
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
        for (int i = 0; i < 3; i++) begin
            send_byte(d[i], ack, pre, post);
            expv = exp_q.pop_front();
            n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wr_ack[%0d]: got %b want 0", i, ack); end
            n_cmp++; if (pre !== prev) begin n_err++; $display("FAIL wr_pre9[%0d]: got %h want %h", i, pre, prev); end
            n_cmp++; if (post !== expv) begin n_err++; $display("FAIL wr_post9[%0d]: got %h want %h", i, post, expv); end
            prev = expv;
        end
        i2c_stop();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL wr_stop_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.io !== 16'h3C77) begin n_err++; $display("FAIL wr_final_io: got %h want 3c77", bus.io); end
    endtask

    task automatic test_addr_mismatch();
        logic         ack0, ack1;
        logic [W-1:0] pre, post;
        int           low0;
        low0 = sda_low_ct;
        mon_sda = 1'b1;
        i2c_start();
        send_byte(8'h42, ack0, pre, post);
        send_byte(8'h00, ack1, pre, post);
        i2c_stop();
        mon_sda = 1'b0;
        n_cmp++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL nm_addr_ack: got %b want 1", ack0); end
        n_cmp++; if (ack1 !== 1'b1) begin n_err++; $display("FAIL nm_data_ack: got %b want 1", ack1); end
        n_cmp++; if (sda_low_ct - low0 !== 0) begin n_err++; $display("FAIL nm_sda_driven: got %0d low samples want 0", sda_low_ct - low0); end
        n_cmp++; if (bus.io !== 16'h3C77) begin n_err++; $display("FAIL nm_io: got %h want 3c77", bus.io); end
    endtask

    task automatic test_reset_mid_write();
        logic         ack;
        logic [W-1:0] pre, post;
        i2c_start();
        send_byte(8'h40, ack, pre, post);
        send_bits(8'hA5, 4);
        reset = 1'b0; m_sda_low = 1'b0; bus.scl = 1'b1;
        #2;
        n_cmp++; if (bus.io !== 16'hFFFF) begin n_err++; $display("FAIL mid_reset_io: got %h want ffff", bus.io); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.int_n !== 1'b1) begin n_err++; $display("FAIL mid_reset_int_n: got %b want 1", bus.int_n); end
        n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL mid_reset_sda: got %b want 1", sda); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_interrupt_read();
        logic         ack;
        logic [W-1:0] pre, post;
        logic [7:0]   b0, b1;
        n_cmp++; if (bus.int_n !== 1'b1) begin n_err++; $display("FAIL int_idle: got %b want 1", bus.int_n); end
        bus.io_in = 16'h5A80;
        repeat (6) @(negedge clk);
        n_cmp++; if (bus.int_n !== 1'b0) begin n_err++; $display("FAIL int_set: got %b want 0", bus.int_n); end
        i2c_start();
        send_byte(8'h41, ack, pre, post);
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
        n_cmp++; if (bus.int_n !== 1'b1) begin n_err++; $display("FAIL int_clear: got %b want 1", bus.int_n); end
        recv_byte(1'b0, b0);
        recv_byte(1'b1, b1);
        n_cmp++; if (b0 !== 8'h80) begin n_err++; $display("FAIL rd_byte0: got %h want 80", b0); end
        n_cmp++; if (b1 !== 8'h5A) begin n_err++; $display("FAIL rd_byte1: got %h want 5a", b1); end
        n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rd_nack_release: got %b want 1", sda); end
        i2c_stop();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rd_stop_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.int_n !== 1'b1) begin n_err++; $display("FAIL int_after_read: got %b want 1", bus.int_n); end
    endtask

    task automatic test_repeated_start();
        logic         ack;
        logic [W-1:0] pre, post;
        i2c_start();
        send_byte(8'h40, ack, pre, post);
        send_bits(8'h12, 4);
        i2c_start();
        send_byte(8'h40, ack, pre, post);
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rs_addr_ack: got %b want 0", ack); end
        send_byte(8'h34, ack, pre, post);
        n_cmp++; if (pre !== 16'hFFFF) begin n_err++; $display("FAIL rs_partial_discard: got %h want ffff", pre); end
        n_cmp++; if (post !== 16'hFF34) begin n_err++; $display("FAIL rs_write: got %h want ff34", post); end
        i2c_stop();
        n_cmp++; if (bus.io !== 16'hFF34) begin n_err++; $display("FAIL rs_final_io: got %h want ff34", bus.io); end
    endtask

    task automatic test_glitch();
        logic         ack0, ack1;
        logic [W-1:0] pre, post;
        int           drop0;
        i2c_start();
        drop0 = busy_drop_ct;
        mon_busy  = 1'b1;
        glitch_en = 1'b1;
        send_byte(8'h40, ack0, pre, post);
        send_byte(8'h99, ack1, pre, post);
        glitch_en = 1'b0;
        mon_busy  = 1'b0;
        i2c_stop();
        n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL gl_addr_ack: got %b want 0", ack0); end
        n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL gl_data_ack: got %b want 0", ack1); end
        n_cmp++; if (busy_drop_ct - drop0 !== 0) begin n_err++; $display("FAIL gl_false_stop: got %0d busy-low samples want 0", busy_drop_ct - drop0); end
        n_cmp++; if (bus.io !== 16'hFF99) begin n_err++; $display("FAIL gl_io: got %h want ff99", bus.io); end
    endtask

    initial begin
        reset = 1'b0;
        m_sda_low = 1'b0;
        test_reset();
        test_write();
        test_addr_mismatch();
        test_reset_mid_write();
        test_interrupt_read();
        test_repeated_start();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_slave_io_expander.md
Name: i2c_slave_io_expander

Overview:
Parameterised, clock-synchronous successor to our 8-bit I2C write-only expander. Imitates a PCF8574/PCF8575-class device with NUM_PORTS byte-wide output ports and readback of NUM_PORTS input bytes. Adds an input-change interrupt and glitch-filtered SCL/SDA. Sits between the board I2C bus and the test-controller I/O.

Parameters:
NUM_PORTS, 1, number of 8-bit ports; io widths are 8*NUM_PORTS.
FILTER_DEPTH, 3, consecutive equal clk samples required before a filtered SCL/SDA level changes.
RESET_VALUE, 8'hFF, value loaded into every output byte on reset.

Ports:
clk  input  1  system clock; minimum 16x SCL frequency.
reset  input  1  asynchronous, active-low reset.
scl  input  1  I2C clock, raw.
sda  inout  1  I2C data, open-drain: driven only to 0, otherwise z.
adr  input  7  device address, static.
io  output  8*NUM_PORTS  output port bytes; byte k is io[8k+7:8k].
io_in  input  8*NUM_PORTS  input pins, asynchronous.
int_n  output  1  active-low input-change interrupt.
busy  output  1  high from a START until the next STOP.

Behaviour:
- Reset values: io = {NUM_PORTS{RESET_VALUE}}, int_n=1, busy=0, sda=z, state IDLE, port_idx=0. Reset is honoured in any state.
- Line conditioning: scl and sda each pass 2-flop sync, then the filter; filtered-level change is 2+FILTER_DEPTH clk after a stable input edge. Edge strobes last 1 clk.
- START: filtered SDA fall while filtered SCL high. STOP: filtered SDA rise while SCL high. Both are detected in every state.
- START or repeated START -> ADDR: bit_ct=0, port_idx=0, busy=1, sda released. A partial byte is discarded.
- STOP -> IDLE, busy=0, sda released. A partial write byte is discarded; io is unchanged.
- Data is sampled on the SCL rise strobe, MSB first. The slave changes sda only on the SCL fall strobe.
- ADDR: 8 bits shift in (7 address bits, then R/W). On the 8th-bit SCL fall:
  - address match -> ADDR_ACK, drive sda=0.
  - no match -> IGNORE; sda stays z until START/STOP.
- ADDR_ACK: on the SCL fall, release sda. R/W=0 -> WRITE. R/W=1 -> load tx shift = io_in byte[port_idx] (synchronised), drive its MSB, -> READ. Address match also sets int_n=1.
- WRITE: 8 bits shift in. On the 8th-bit SCL fall, drive sda=0 -> WRITE_ACK.
- WRITE_ACK: on the 9th-clock SCL rise, io byte[port_idx] <= received byte; this is the single-clk update point. On the SCL fall, release sda, port_idx <= (port_idx+1) mod NUM_PORTS, -> WRITE.
- READ: shift out on SCL fall. After 8 bits, release sda -> READ_ACK.
- READ_ACK: sample the master bit on SCL rise.
  - ACK (0): port_idx increments with wrap, next byte loaded, -> READ on the SCL fall.
  - NACK (1): -> IGNORE.
- Interrupt: synchronised io_in is compared each clk to the snapshot taken at the last read load (reset snapshot = io_in after sync). Any difference sets int_n=0 and holds it until the next address match. If the clear and a new change occur in the same clk, the set wins.
- A START in the middle of any byte or ACK phase aborts cleanly, and sda is released within 1 clk.
- Never drive sda=1.

Decomposition:
- Shared package i2c_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE).
  - ADDR_WIDTH=7, I2C_ACK=0, I2C_NACK=1.
- Sub-module i2c_line_filter: sync, FILTER_DEPTH glitch filter, and rise/fall strobes. Instantiated for scl and sda.
- Top: FSM, bit counter, shift registers, port_idx, interrupt logic.

Test Plan:
- Reset with NUM_PORTS=2, adr=7'h20 -> io=16'hFFFF, int_n=1, busy=0, sda=z; assert reset mid-write -> same values immediately.
- START, 0x40, 0xA5, 0x3C, 0x77, STOP -> three ACKs; io byte0=0xA5, byte1=0x3C, then byte0=0x77 (wrap); each update lands on the 9th SCL rise.
- START, 0x42 (address mismatch), 0x00, STOP -> sda never driven low; io unchanged.
- io_in=16'h5A81 changes to 16'h5A80 -> int_n=0; START, 0x41 -> ACK, int_n=1; master reads 0x80 (ACK), 0x5A (NACK), STOP -> sda released after NACK.
- Write 0x40, 0x12 with a repeated START after 4 data bits, then 0x40, 0x34, STOP -> io byte0=0x34; the partial byte is discarded.
- 1-clk-wide glitches on scl/sda with FILTER_DEPTH=3 during a write of 0x40, 0x99 -> no false START/STOP; io byte0=0x99.
